// File: rtl/pmt_credit_ctrl_if.sv
// Host/relay-facing signal bundle for the permit credit controller.
// The master side is the host plus relay; the slave side is the controller.
interface pmt_credit_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             i_start;
  logic [CNT_W-1:0] i_credits;
  logic             i_abort;
  logic             i_fire;
  logic             o_pmt;
  logic             o_busy;
  logic             o_done;
  logic [CNT_W-1:0] o_fired_cnt;
  logic             o_ovr;

  modport master (
    output i_start, i_credits, i_abort, i_fire,
    input  o_pmt, o_busy, o_done, o_fired_cnt, o_ovr
  );

  modport slave (
    input  i_start, i_credits, i_abort, i_fire,
    output o_pmt, o_busy, o_done, o_fired_cnt, o_ovr
  );
endinterface

// File: rtl/pmt_credit_ctrl.sv
// Permit controller for a permit-gated click FIFO stage: grants a token budget,
// counts synchronized relay fires, then waits for the pipeline to go quiet.
module pmt_credit_ctrl #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DRAIN_CYC   = 8
) (
  input  logic             clk,
  input  logic             rst,
  pmt_credit_ctrl_if.slave bus
);
  localparam int unsigned TMR_W = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DRAIN_CYC);

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_DRAIN, ST_DONE} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   fire_det;
  logic [CNT_W-1:0]       rem_q, rem_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic                   pmt_q, pmt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   ovr_q, ovr_d;

  // Fire synchronizer; fire_det is a registered one-cycle rising-edge pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      fire_det <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.i_fire};
      edge_q   <= sync_q[SYNC_STAGES-1];
      fire_det <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    pmt_d   = pmt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          cnt_d = '0;
          ovr_d = 1'b0;
          rem_d = bus.i_credits;
          if (bus.i_credits != '0) begin
            pmt_d   = 1'b1;
            state_d = ST_ARM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ARM: begin
        if (fire_det) begin
          cnt_d = cnt_inc;
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
        end
        if ((fire_det && rem_q == CNT_W'(1)) || bus.i_abort) begin
          pmt_d   = 1'b0;
          tmr_d   = TMR_LOAD;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fire_det) begin
          cnt_d = cnt_inc;
          tmr_d = TMR_LOAD;
          if (rem_q == '0) ovr_d = 1'b1;
          else             rem_d = rem_q - CNT_W'(1);
        end else if (tmr_q <= TMR_W'(1)) begin
          tmr_d   = '0;
          state_d = ST_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ARM) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      pmt_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pmt_q   <= pmt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.o_pmt       = pmt_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_fired_cnt = cnt_q;
  assign bus.o_ovr       = ovr_q;
endmodule

// File: doc/pmt_credit_ctrl.md
# pmt_credit_ctrl

Clocked permit controller that drives the `pmt` input of a permit-gated click FIFO stage and consumes its `o_fire_1` completion pulses. A host loads a token budget; the block raises `pmt`, counts relay fires through a synchronizer, and drops `pmt` when the budget is spent or on abort. It then waits for the asynchronous pipeline to go quiet and reports completion.

## Interface
- `CNT_W`, 16, width of the credit and fire counters.
- `SYNC_STAGES`, 2, flip-flop stages in the `i_fire` synchronizer (minimum 2).
- `DRAIN_CYC`, 8, number of consecutive fire-free cycles that ends the drain phase (minimum 1).

- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `i_start`  in  1  one-cycle start request. Sampled only in IDLE.
- `i_credits`  in  CNT_W  token budget, sampled with `i_start`.
- `i_abort`  in  1  level; terminates the ARM phase early.
- `i_fire`  in  1  asynchronous fire pulse from the relay (`o_fire_1`). Every pulse is high for ≥1.5 `clk` periods and low for ≥1.5 `clk` periods.
- `o_pmt`  out  1  permit to the relay; registered.
- `o_busy`  out  1  high in ARM and DRAIN.
- `o_done`  out  1  one-cycle completion pulse.
- `o_fired_cnt`  out  CNT_W  fires counted since the last accepted start. Saturates at all-ones.
- `o_ovr`  out  1  sticky flag: a fire was detected while the remaining credit was 0. Cleared on start.

## Operation
- Synchronizer: `i_fire` passes through `SYNC_STAGES` flops plus one edge-detect flop. A rising edge produces a one-cycle internal `fire_det`.
- States and transitions:
  - IDLE to ARM: `i_start` with `i_credits != 0`. Load `rem = i_credits`, clear `o_fired_cnt` and `o_ovr`, set `o_pmt = 1`.
  - IDLE to DONE: `i_start` with `i_credits == 0`. Clear the counters; `o_pmt` stays 0.
  - ARM on `fire_det`: `rem` decrements and `o_fired_cnt` increments.
  - ARM to DRAIN: on `fire_det` when `rem == 1`, clear `o_pmt`, set `rem = 0`, load the drain timer with `DRAIN_CYC`.
  - ARM to DRAIN: on `i_abort`, clear `o_pmt` and load the drain timer. `rem` is held.
  - DRAIN on `fire_det`: `o_fired_cnt` increments, the timer reloads to `DRAIN_CYC`, and `o_ovr` sets if `rem == 0`.
  - DRAIN on a cycle without `fire_det`: the timer decrements.
  - DRAIN to DONE: when the timer reaches 0.
  - DONE to IDLE: unconditionally after one cycle. `o_done = 1` only in DONE.
- Simultaneous events:
  - `i_abort` and `fire_det` in the same ARM cycle: the fire is counted, then the block goes to DRAIN.
  - If `rem == 1` in that cycle, `rem` becomes 0.
- `i_start` outside IDLE is ignored. `i_abort` outside ARM is ignored.
- `o_fired_cnt` saturates at 2^CNT_W−1 and never wraps. `rem` never underflows: a fire with `rem == 0` does not decrement.
- `rst` mid-operation: the next edge forces IDLE. All outputs become 0, the counters and synchronizer flops clear, and `o_pmt` drops on that edge.

## Timing
- Reset values: `o_pmt = 0`, `o_busy = 0`, `o_done = 0`, `o_fired_cnt = 0`, `o_ovr = 0`.
- `i_start` sampled at edge N gives `o_pmt = 1` and `o_busy = 1` from edge N.
- `i_fire` rising edge to `fire_det` takes `SYNC_STAGES + 1` edges; the count updates on the next edge.
- `o_pmt` deasserts on the edge where the final credit's `fire_det` is registered. Fires already launched before then are counted in DRAIN.
- Last fire to `o_done`: `DRAIN_CYC + 1` cycles after its `fire_det`.
- `o_busy` falls in the same cycle that `o_done` rises.
- `o_done` is high for exactly one cycle.
- Zero-credit start: `o_done` is high in cycle N+1.

## Test plan
- Reset then idle: hold `rst` 3 cycles, then `i_fire` toggles with no start. All outputs stay 0 and `o_fired_cnt` stays 0.
- Normal budget: start with `i_credits = 3`, then 3 fires spaced 10 cycles apart. `o_pmt` high until the third `fire_det`, `o_fired_cnt = 3`, `o_ovr = 0`, `o_done` at 9 cycles after the third `fire_det` (default `DRAIN_CYC = 8`).
- Overrun: `i_credits = 1`, then two fires 4 cycles apart. `o_fired_cnt = 2`, `o_ovr = 1`, drain timer restarted, and `o_done` at 9 cycles after the second `fire_det`.
- Abort: `i_credits = 5`, 2 fires, then `i_abort`. `o_pmt` falls on the next edge, `o_fired_cnt = 2`, `o_done` after 9 quiet cycles, `o_ovr = 0`.
- Zero credits and busy start: start with `i_credits = 0` gives `o_done` next cycle and `o_pmt` never high. A second `i_start` during ARM is ignored and `rem` is unchanged.
- Mid-run reset: assert `rst` during ARM after 1 fire. All outputs are 0 on the next edge, and a subsequent start with `i_credits = 2` behaves normally.
